// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: control-bundle bit layout, r0 constant and
// the ID/EX pipeline register bundle.
package mips_pkg;

   localparam int XLEN   = 32;
   localparam int RADR_W = 5;
   localparam int CTRL_W = 12;

   // Decoded control bundle bit positions
   localparam int CTRL_REGWRITE  = 0;
   localparam int CTRL_MEMREAD   = 1;
   localparam int CTRL_MEMWRITE  = 2;
   localparam int CTRL_ALUSRC    = 3;
   localparam int CTRL_ALUOP_LSB = 4;
   localparam int CTRL_ALUOP_MSB = 7;

   localparam logic [RADR_W-1:0] REG_ZERO = '0;

   // EX register bundle
   typedef struct packed {
      logic              valid;
      logic [RADR_W-1:0] rs;
      logic [RADR_W-1:0] rt;
      logic [RADR_W-1:0] rd;
      logic [XLEN-1:0]   a;
      logic [XLEN-1:0]   b;
      logic [XLEN-1:0]   imm;
      logic [CTRL_W-1:0] ctrl;
   } id_ex_t;

   // True when a writeback in flight targets the given read address
   function automatic logic wb_hit(input logic we,
                                   input logic [RADR_W-1:0] wadr,
                                   input logic [RADR_W-1:0] radr);
      return we && (wadr == radr);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: IF/ID fields, regFile read data, writeback snoop,
// pipeline control in, and the registered EX bundle out.
interface id_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int ADR_W  = 5,
   parameter int CTRL_W = mips_pkg::CTRL_W
);
   logic              id_valid;
   logic [ADR_W-1:0]  id_rs;
   logic [ADR_W-1:0]  id_rt;
   logic [ADR_W-1:0]  id_rd;
   logic              id_uses_rt;
   logic [DATA_W-1:0] id_imm;
   logic [CTRL_W-1:0] id_ctrl;
   logic [DATA_W-1:0] rf_data1;
   logic [DATA_W-1:0] rf_data2;
   logic              wb_regWrite;
   logic [ADR_W-1:0]  wb_adr;
   logic [DATA_W-1:0] wb_data;
   logic              flush;
   logic              ex_hold;
   logic              stall;
   logic              ex_valid;
   logic [ADR_W-1:0]  ex_rs;
   logic [ADR_W-1:0]  ex_rt;
   logic [ADR_W-1:0]  ex_rd;
   logic [DATA_W-1:0] ex_a;
   logic [DATA_W-1:0] ex_b;
   logic [DATA_W-1:0] ex_imm;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [31:0]       stall_cnt;

   // Decode side / pipeline control
   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_imm, id_ctrl,
             rf_data1, rf_data2, wb_regWrite, wb_adr, wb_data, flush, ex_hold,
      input  stall, ex_valid, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm,
             ex_ctrl, stall_cnt
   );

   // The ID/EX stage itself
   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_imm, id_ctrl,
             rf_data1, rf_data2, wb_regWrite, wb_adr, wb_data, flush, ex_hold,
      output stall, ex_valid, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm,
             ex_ctrl, stall_cnt
   );
endinterface

// File: rtl/id_ex_stage_operand_bypass.sv
// operand_bypass: picks one source operand. r0 reads as zero (regFile does
// not protect it), and a same-cycle writeback to the read address wins over
// the stale combinational regFile data.
module operand_bypass #(
   parameter int DATA_W = 32,
   parameter int ADR_W  = 5
) (
   input  logic [ADR_W-1:0]  addr,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              wb_we,
   input  logic [ADR_W-1:0]  wb_adr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] opnd
);
   import mips_pkg::*;

   // r0 first, then writeback forward, else regFile
   always_comb begin
      opnd = rf_data;
      if (addr == ADR_W'(REG_ZERO))
         opnd = '0;
      else if (wb_hit(wb_we, wb_adr, addr))
         opnd = wb_data;
   end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register of the 5-stage MIPS core with r0 /
// writeback bypass, load-use bubble insertion, branch flush and downstream
// hold. Optional load-use stall counter enabled by `define STALL_CNT_EN;
// without it stall_cnt is tied to 0.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int ADR_W  = 5,
   parameter int CTRL_W = mips_pkg::CTRL_W
) (
   input logic         clk,
   input logic         rst,
   id_ex_stage_if.slave bus
);
   import mips_pkg::*;

   id_ex_t            ex_d, ex_q;
   logic              lu;
   logic [DATA_W-1:0] op_a, op_b;

   operand_bypass #(.DATA_W(DATA_W), .ADR_W(ADR_W)) u_byp_rs (
      .addr   (bus.id_rs),
      .rf_data(bus.rf_data1),
      .wb_we  (bus.wb_regWrite),
      .wb_adr (bus.wb_adr),
      .wb_data(bus.wb_data),
      .opnd   (op_a)
   );

   operand_bypass #(.DATA_W(DATA_W), .ADR_W(ADR_W)) u_byp_rt (
      .addr   (bus.id_rt),
      .rf_data(bus.rf_data2),
      .wb_we  (bus.wb_regWrite),
      .wb_adr (bus.wb_adr),
      .wb_data(bus.wb_data),
      .opnd   (op_b)
   );

   // Load in EX whose destination is a source of the valid ID instruction
   always_comb begin
      lu = bus.id_valid && ex_q.valid && ex_q.ctrl[CTRL_MEMREAD] &&
           (ex_q.rt != REG_ZERO) &&
           ((ex_q.rt == bus.id_rs) || (bus.id_uses_rt && (ex_q.rt == bus.id_rt)));
   end

   // A flush kills the ID instruction, so holding IF/ID would be pointless
   assign bus.stall = !rst && !bus.flush && (lu || bus.ex_hold);

   // EX register next state: hold > flush > bubble > capture
   always_comb begin
      ex_d = ex_q;
      if (bus.ex_hold) begin
         ex_d = ex_q;
      end else if (bus.flush || lu) begin
         ex_d = '0;
      end else begin
         ex_d.valid = bus.id_valid;
         ex_d.rs    = bus.id_rs;
         ex_d.rt    = bus.id_rt;
         ex_d.rd    = bus.id_rd;
         ex_d.a     = op_a;
         ex_d.b     = op_b;
         ex_d.imm   = bus.id_imm;
         ex_d.ctrl  = bus.id_valid ? bus.id_ctrl : '0;
      end
   end

   // EX register
   always_ff @(posedge clk) begin
      if (rst) ex_q <= '0;
      else     ex_q <= ex_d;
   end

   assign bus.ex_valid = ex_q.valid;
   assign bus.ex_rs    = ex_q.rs;
   assign bus.ex_rt    = ex_q.rt;
   assign bus.ex_rd    = ex_q.rd;
   assign bus.ex_a     = ex_q.a;
   assign bus.ex_b     = ex_q.b;
   assign bus.ex_imm   = ex_q.imm;
   assign bus.ex_ctrl  = ex_q.ctrl;

`ifdef STALL_CNT_EN
   logic [31:0] stall_cnt_d, stall_cnt_q;

   // Count bubbles actually inserted; saturate rather than wrap
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (lu && !bus.flush && !bus.ex_hold && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // Stall counter register
   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign bus.stall_cnt = stall_cnt_q;
`else
   assign bus.stall_cnt = '0;
`endif

endmodule
